nano_mem_arbiter: RTL and testbench

Two-port arbiter sharing the nano core's single-port program/data RAM between the CPU fetch/load-store port and the debug/loader port. Sits inside `nano_project_top` between the CPU, the debug UART bridge and the synchronous RAM. Provides round-robin access, a debug halt mode that gives the loader exclusive ownership, and a saturating CPU-stall counter for profiling.

---
 rtl/nano_pkg.sv | 10 +
 rtl/nano_rr_arb2.sv | 27 ++
 rtl/nano_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_nano_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nano_pkg.sv
// Shared types and default bus widths for the nano core, its RAM and the RAM arbiter.
package nano_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {RUN, HALTING, HALTED} halt_state_t;
  typedef enum logic {REQ_CPU, REQ_DBG} req_id_t;

endpackage

// File: rtl/nano_rr_arb2.sv
// Two-way round-robin grant, purely combinational (0 cycles); gnt_o[0]=CPU, gnt_o[1]=DBG.
// On a tie the port that did not win last time gets the grant; losers simply wait.
module nano_rr_arb2
  import nano_pkg::*;
(
  input  logic       cpu_elig_i,
  input  logic       dbg_elig_i,
  input  req_id_t    last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (cpu_elig_i && dbg_elig_i) begin
      if (last_i == REQ_DBG) begin
        gnt_o = 2'b01;
      end else begin
        gnt_o = 2'b10;
      end
    end else if (cpu_elig_i) begin
      gnt_o = 2'b01;
    end else if (dbg_elig_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/nano_mem_arbiter.sv
// Shares the single-port RAM between CPU and debug: combinational ack, read data one cycle later.
// A port not acked just holds its request; dbg_halt locks the CPU out entirely.
module nano_mem_arbiter #(
  parameter int ADDR_W = nano_pkg::ADDR_W,
  parameter int DATA_W = nano_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,

  input  logic              dbg_halt,
  output logic              halted,

  input  logic              stat_clr,
  output logic [CNT_W-1:0]  cpu_stall_cnt,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  import nano_pkg::*;

  halt_state_t      state_q, state_d;
  req_id_t          last_q, last_d;
  logic             cpu_pend_q, cpu_pend_d;
  logic             dbg_pend_q, dbg_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             cpu_elig;
  logic             dbg_elig;
  logic [1:0]       gnt;
  logic             gnt_cpu;
  logic             gnt_dbg;

  // Eligibility is gated by reset so no ack or RAM strobe leaks out while reset is held.
  assign cpu_elig = reset_n && cpu_req && (state_q == RUN);
  assign dbg_elig = reset_n && dbg_req;

  nano_rr_arb2 u_rr_arb2 (
    .cpu_elig_i (cpu_elig),
    .dbg_elig_i (dbg_elig),
    .last_i     (last_q),
    .gnt_o      (gnt)
  );

  assign gnt_cpu = gnt[0];
  assign gnt_dbg = gnt[1];
  assign cpu_ack = gnt_cpu;
  assign dbg_ack = gnt_dbg;

  always_comb begin
    mem_en    = gnt_cpu | gnt_dbg;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_cpu) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (gnt_dbg) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_cpu) begin
      last_d = REQ_CPU;
    end else if (gnt_dbg) begin
      last_d = REQ_DBG;
    end
  end

  // The RAM returns read data one cycle after the strobe; tag it with the requesting port.
  assign cpu_pend_d = gnt_cpu & ~cpu_we;
  assign dbg_pend_d = gnt_dbg & ~dbg_we;

  assign cpu_rvalid = cpu_pend_q;
  assign cpu_rdata  = mem_rdata;
  assign dbg_rvalid = dbg_pend_q;
  assign dbg_rdata  = mem_rdata;

  // No CPU grants happen outside RUN, so a read caught in HALTING returns during that cycle.
  always_comb begin
    state_d = state_q;
    halted  = 1'b0;
    case (state_q)
      RUN: begin
        if (dbg_halt) begin
          state_d = HALTING;
        end
      end
      HALTING: begin
        if (!dbg_halt) begin
          state_d = RUN;
        end else if (!cpu_pend_d) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        halted = 1'b1;
        if (!dbg_halt) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stat_clr) begin
      stall_cnt_d = '0;
    end else if (cpu_req && !gnt_cpu && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign cpu_stall_cnt = stall_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      last_q      <= REQ_DBG;
      cpu_pend_q  <= 1'b0;
      dbg_pend_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cpu_pend_q  <= cpu_pend_d;
      dbg_pend_q  <= dbg_pend_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_nano_mem_arbiter.sv
// Bench for nano_mem_arbiter: directed stimulus, a rule-level model compared every cycle,
// and hand-computed literal expectations at the interesting points.
module tb_nano_mem_arbiter;

  localparam int AW   = 12;
  localparam int DW   = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          cpu_req, cpu_we, cpu_ack, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_ack, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          dbg_halt, halted, stat_clr;
  logic [CW-1:0] cpu_stall_cnt;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  nano_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_halt(dbg_halt), .halted(halted),
    .stat_clr(stat_clr), .cpu_stall_cnt(cpu_stall_cnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port RAM behind the arbiter.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_q;
  assign mem_rdata = ram_q;
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_q <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: previous winner, dbg_halt history, outstanding reads, stall count, memory.
  int            m_last = 1;
  bit            m_h1 = 0, m_h2 = 0;
  bit            m_cpu_pend = 0, m_dbg_pend = 0;
  logic [DW-1:0] m_cpu_data, m_dbg_data;
  int            m_cnt = 0;
  logic [DW-1:0] m_mem [0:(1<<AW)-1];

  always @(negedge clock) begin
    bit            ce, de, e_we;
    int            win;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    if (!reset_n) begin
      check("rst cpu_ack", cpu_ack, 0);
      check("rst dbg_ack", dbg_ack, 0);
      check("rst mem_en", mem_en, 0);
      check("rst cpu_rvalid", cpu_rvalid, 0);
      check("rst dbg_rvalid", dbg_rvalid, 0);
      check("rst halted", halted, 0);
      check("rst stall_cnt", cpu_stall_cnt, 0);
      m_last = 1; m_h1 = 0; m_h2 = 0;
      m_cpu_pend = 0; m_dbg_pend = 0; m_cnt = 0;
    end else begin
      // The CPU is locked out in any cycle that follows a cycle with dbg_halt high.
      ce = cpu_req && !m_h1;
      de = dbg_req;
      if (ce && de)  win = (m_last == 1) ? 0 : 1;
      else if (ce)   win = 0;
      else if (de)   win = 1;
      else           win = -1;
      e_we   = (win == 0) ? cpu_we   : (win == 1) ? dbg_we   : 1'b0;
      e_addr = (win == 0) ? cpu_addr : (win == 1) ? dbg_addr : '0;
      e_wd   = (win == 0) ? cpu_wdata: (win == 1) ? dbg_wdata: '0;

      check("cpu_ack", cpu_ack, win == 0);
      check("dbg_ack", dbg_ack, win == 1);
      check("mem_en", mem_en, win >= 0);
      check("mem_we", mem_we, e_we);
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wd);
      check("cpu_rvalid", cpu_rvalid, m_cpu_pend);
      if (m_cpu_pend) check("cpu_rdata", cpu_rdata, m_cpu_data);
      check("dbg_rvalid", dbg_rvalid, m_dbg_pend);
      if (m_dbg_pend) check("dbg_rdata", dbg_rdata, m_dbg_data);
      check("halted", halted, m_h1 && m_h2);
      check("stall_cnt", cpu_stall_cnt, m_cnt);

      m_cpu_pend = (win == 0) && !e_we;
      m_dbg_pend = (win == 1) && !e_we;
      if (win >= 0) begin
        if (e_we)          m_mem[e_addr] = e_wd;
        else if (win == 0) m_cpu_data = m_mem[e_addr];
        else               m_dbg_data = m_mem[e_addr];
        m_last = win;
      end
      if (stat_clr)                                  m_cnt = 0;
      else if (cpu_req && win != 0 && m_cnt < CMAX)  m_cnt++;
      m_h2 = m_h1;
      m_h1 = dbg_halt;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n_cpu, n_dbg;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]   = '0;
      m_mem[i] = '0;
    end
    ram_q = '0;
    reset_n = 0; dbg_halt = 0; stat_clr = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;

    // Reset with both ports requesting, then release: CPU wins the first tie.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset cpu_ack", cpu_ack, 0);
    check("reset dbg_ack", dbg_ack, 0);
    check("reset mem_en", mem_en, 0);
    check("reset halted", halted, 0);
    step(); reset_n = 1;
    @(negedge clock);
    check("first tie cpu_ack", cpu_ack, 1);
    check("first tie dbg_ack", dbg_ack, 0);
    step();
    @(negedge clock);
    check("second tie dbg_ack", dbg_ack, 1);
    check("second tie cpu_ack", cpu_ack, 0);

    // Debug writes 0x1234 to 0x005, CPU reads it back one cycle after its ack.
    step(); cpu_req = 0; dbg_req = 1; dbg_we = 1; dbg_addr = 12'h005; dbg_wdata = 16'h1234;
    @(negedge clock);
    check("dbg write ack", dbg_ack, 1);
    step(); dbg_req = 0; dbg_we = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 12'h005;
    @(negedge clock);
    check("cpu read ack", cpu_ack, 1);
    step(); cpu_req = 0;
    @(negedge clock);
    check("read cpu_rvalid", cpu_rvalid, 1);
    check("read cpu_rdata", cpu_rdata, 16'h1234);
    check("read dbg_rvalid", dbg_rvalid, 0);

    // Ten cycles of contention: strict alternation.
    step(); stat_clr = 1;
    step(); stat_clr = 0; cpu_req = 1; cpu_addr = 12'h005; dbg_req = 1; dbg_addr = 12'h006;
    n_cpu = 0; n_dbg = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_cpu += int'(cpu_ack);
      n_dbg += int'(dbg_ack);
      step();
    end
    cpu_req = 0; dbg_req = 0;
    @(negedge clock);
    check("fair cpu acks", n_cpu, 5);
    check("fair dbg acks", n_dbg, 5);
    check("fair stall_cnt", cpu_stall_cnt, 5);

    // Halt raised in the same cycle as a CPU read.
    step(); cpu_req = 1; cpu_addr = 12'h005; dbg_halt = 1;
    @(negedge clock);
    check("halt edge cpu_ack", cpu_ack, 1);
    step(); dbg_req = 1; dbg_we = 1; dbg_addr = 12'h007; dbg_wdata = 16'hbeef;
    @(negedge clock);
    check("halting cpu_rvalid", cpu_rvalid, 1);
    check("halting cpu_rdata", cpu_rdata, 16'h1234);
    check("halting cpu_ack", cpu_ack, 0);
    check("halting dbg_ack", dbg_ack, 1);
    check("halting halted", halted, 0);
    step(); dbg_addr = 12'h008; dbg_wdata = 16'h0042;
    @(negedge clock);
    check("halted flag", halted, 1);
    check("halted cpu_ack", cpu_ack, 0);
    check("halted dbg_ack", dbg_ack, 1);
    step(); dbg_we = 0; dbg_addr = 12'h007;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("halted dbg every cycle", dbg_ack, 1);
      step();
    end
    dbg_halt = 0; dbg_req = 0;
    @(negedge clock);
    check("halted dbg_rdata", dbg_rdata, 16'hbeef);
    check("unhalt cycle cpu_ack", cpu_ack, 0);
    step();
    @(negedge clock);
    check("resume cpu_ack", cpu_ack, 1);
    check("resume halted", halted, 0);

    // Halt dropped while still HALTING: halted never asserts.
    step(); cpu_req = 0; dbg_halt = 1;
    step(); dbg_halt = 0;
    @(negedge clock);
    check("abort halted", halted, 0);
    step(); cpu_req = 1;
    @(negedge clock);
    check("abort halted after", halted, 0);
    check("abort resume cpu_ack", cpu_ack, 1);

    // Stall counter saturation and clear.
    step(); cpu_req = 0; stat_clr = 1; dbg_halt = 1;
    step(); stat_clr = 0; cpu_req = 1;
    repeat (20) step();
    @(negedge clock);
    check("saturated stall_cnt", cpu_stall_cnt, 15);
    step(); stat_clr = 1;
    step(); stat_clr = 0;
    @(negedge clock);
    check("cleared stall_cnt", cpu_stall_cnt, 0);
    step();
    @(negedge clock);
    check("count after clear", cpu_stall_cnt, 1);
    step(); cpu_req = 0; dbg_halt = 0;
    step();

    // Reset asserted while a CPU read is in flight.
    cpu_req = 1; cpu_addr = 12'h005;
    @(negedge clock);
    check("pre-reset cpu_ack", cpu_ack, 1);
    step(); cpu_req = 0;
    check("pre-reset cpu_rvalid", cpu_rvalid, 1);
    reset_n = 0;
    #1;
    check("reset drops rvalid", cpu_rvalid, 0);
    step(); reset_n = 1;
    @(negedge clock);
    check("post-reset rvalid", cpu_rvalid, 0);
    step();
    @(negedge clock);
    check("post-reset rvalid later", cpu_rvalid, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
